// File: rtl/clk_en_pkg.sv
// Shared encodings and defaults for the clock-enable generator and its
// button debouncer.
package clk_en_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_STEP = 2'd1,
    MODE_HALT = 2'd2
  } mode_e;

  localparam int unsigned DEF_DB_CYCLES = 32'd1_000_000;
  localparam int          DEF_DIV_W     = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for a raw push button.
// Produces the accepted level and a one-cycle pulse on its rising edge.
module btn_debounce
  import clk_en_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned     CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_s0;
  logic          r_s1;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  // The counter only advances while the synchronised input disagrees with
  // the accepted level, so any agreement restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_s0      <= i_btn;
      r_s1      <= r_s0;
      r_level_d <= r_level;
      if (r_s1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_s1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/clk_en_gen.sv
// Free-running cycle counter, NUM_CH programmable tick channels and a CPU
// clock enable with run / debounced single-step / halt modes.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          DIV_W     = DEF_DIV_W,
  parameter int          CNT_W     = 32,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [1:0]              mode_i,
  input  logic                    step_btn_i,
  output logic [CNT_W-1:0]        clkdiv_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic                    cpu_ce_o,
  output logic                    db_btn_o
);

  logic [CNT_W-1:0]  r_clkdiv;
  logic [NUM_CH-1:0] w_term;
  logic [NUM_CH-1:0] w_tick;
  logic              w_level;
  logic              w_rise;
  logic              w_ce_next;
  logic              r_cpu_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clkdiv <= '0;
    else        r_clkdiv <= r_clkdiv + CNT_W'(1);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] w_div;
    logic [DIV_W-1:0] w_last;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    assign w_div  = div_i[k*DIV_W +: DIV_W];
    // A zero divisor behaves as divide-by-one.
    assign w_last = (w_div == '0) ? '0 : w_div - DIV_W'(1);
    // ">=" rather than "==" so a divisor lowered below the running count
    // terminates immediately instead of wrapping the counter.
    assign w_term[k] = ch_en_i[k] && (r_cnt >= w_last);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (!ch_en_i[k]) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (w_term[k]) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
        r_tick <= 1'b0;
      end
    end

    assign w_tick[k] = r_tick;
  end

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (step_btn_i),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  // Mode is applied live, so a step edge seen outside STEP is simply lost.
  always_comb begin
    w_ce_next = 1'b0;
    case (mode_i)
      MODE_RUN:  w_ce_next = w_term[0];
      MODE_STEP: w_ce_next = w_rise;
      default:   w_ce_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cpu_ce <= 1'b0;
    else        r_cpu_ce <= w_ce_next;
  end

  assign clkdiv_o = r_clkdiv;
  assign tick_o   = w_tick;
  assign cpu_ce_o = r_cpu_ce;
  assign db_btn_o = w_level;

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: per-scenario tasks checked against a behavioural
// model built from the tick-period and button-stability rules.
module tb_clk_en_gen;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int DB    = 4;
  localparam logic [1:0] M_RUN  = 2'd0;
  localparam logic [1:0] M_STEP = 2'd1;
  localparam logic [1:0] M_HALT = 2'd2;

  logic              clk;
  logic              rst_n;
  logic [NCH*DW-1:0] div_i;
  logic [NCH-1:0]    ch_en_i;
  logic [1:0]        mode_i;
  logic              step_btn_i;
  logic [CW-1:0]     clkdiv_o;
  logic [NCH-1:0]    tick_o;
  logic              cpu_ce_o;
  logic              db_btn_o;

  int n_checks;
  int n_fail;
  int ecnt;

  // model state
  int            m_elapsed[NCH];
  logic [NCH-1:0] m_tick;
  logic [CW-1:0] m_clkdiv;
  logic          m_db;
  logic          m_db_prev;
  logic          m_ce;
  logic          m_hist[$];

  clk_en_gen #(
    .NUM_CH    (NCH),
    .DIV_W     (DW),
    .CNT_W     (CW),
    .DB_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_i      (div_i),
    .ch_en_i    (ch_en_i),
    .mode_i     (mode_i),
    .step_btn_i (step_btn_i),
    .clkdiv_o   (clkdiv_o),
    .tick_o     (tick_o),
    .cpu_ce_o   (cpu_ce_o),
    .db_btn_o   (db_btn_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_elapsed[k] = 0;
    m_tick    = '0;
    m_clkdiv  = '0;
    m_db      = 1'b0;
    m_db_prev = 1'b0;
    m_ce      = 1'b0;
    m_hist    = {};
    for (int j = 0; j < DB + 2; j++) m_hist.push_back(1'b0);
  endtask

  // One rising edge: the model consumes the inputs the DUT samples there.
  // hist[0] is the button sampled one edge ago; the synchronised value seen
  // at this edge is the sample from two edges ago (hist[1]).
  task automatic clk_edge();
    logic [NCH-1:0] nt;
    logic           all_diff;
    int             d;
    @(posedge clk);
    ecnt++;
    for (int k = 0; k < NCH; k++) begin
      nt[k] = 1'b0;
      if (!ch_en_i[k]) begin
        m_elapsed[k] = 0;
      end else begin
        d = int'(div_i[k*DW +: DW]);
        if (d == 0) d = 1;
        m_elapsed[k]++;
        if (m_elapsed[k] >= d) begin
          nt[k] = 1'b1;
          m_elapsed[k] = 0;
        end
      end
    end
    all_diff = 1'b1;
    for (int j = 1; j <= DB; j++) if (m_hist[j] == m_db) all_diff = 1'b0;
    case (mode_i)
      M_RUN:   m_ce = nt[0];
      M_STEP:  m_ce = m_db & ~m_db_prev;
      default: m_ce = 1'b0;
    endcase
    m_db_prev = m_db;
    if (all_diff) m_db = ~m_db;
    m_tick   = nt;
    m_clkdiv = m_clkdiv + CW'(1);
    m_hist.push_front(step_btn_i);
    void'(m_hist.pop_back());
    #1;
  endtask

  // driver tasks
  task automatic set_div(input int k, input int v);
    div_i[k*DW +: DW] = DW'(v);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    int second;
    n_checks++;
    if ({clkdiv_o, tick_o, cpu_ce_o, db_btn_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got %0h expected 0", {clkdiv_o, tick_o, cpu_ce_o, db_btn_o});
    end
    rst_n = 1'b1;
    ch_en_i = 4'b0001;
    set_div(0, 5);
    repeat (7) clk_edge();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clkdiv_o, tick_o, cpu_ce_o, db_btn_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %0h expected 0", {clkdiv_o, tick_o, cpu_ce_o, db_btn_o});
    end
    apply_reset();
    first  = -1;
    second = -1;
    for (int i = 1; i <= 12; i++) begin
      clk_edge();
      n_checks++;
      if (tick_o[0] !== m_tick[0]) begin
        n_fail++;
        $display("FAIL reset_tick0 edge %0d: got %b expected %b", i, tick_o[0], m_tick[0]);
      end
      if (tick_o[0] === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    n_checks++;
    if (first != 5) begin
      n_fail++;
      $display("FAIL reset_first_tick: got edge %0d expected 5", first);
    end
    n_checks++;
    if (second - first != 5) begin
      n_fail++;
      $display("FAIL reset_period: got %0d expected 5", second - first);
    end
  endtask

  task automatic test_channels();
    int cnt[NCH];
    set_div(0, 1); set_div(1, 2); set_div(2, 3); set_div(3, 0);
    ch_en_i = 4'hF;
    for (int k = 0; k < NCH; k++) cnt[k] = 0;
    for (int i = 0; i < 12; i++) begin
      clk_edge();
      n_checks++;
      if (tick_o !== m_tick) begin
        n_fail++;
        $display("FAIL channels_tick: got %b expected %b", tick_o, m_tick);
      end
      for (int k = 0; k < NCH; k++) if (tick_o[k] === 1'b1) cnt[k]++;
    end
    n_checks++;
    if (cnt[0] != 12 || cnt[1] != 6 || cnt[2] != 4 || cnt[3] != 12) begin
      n_fail++;
      $display("FAIL channels_counts: got %0d %0d %0d %0d expected 12 6 4 12",
               cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    // lower ch1 divisor 8 -> 2 with six cycles already counted
    set_div(1, 8);
    for (int i = 0; i < 20 && !(m_elapsed[1] == 6); i++) clk_edge();
    set_div(1, 2);
    clk_edge();
    n_checks++;
    if (tick_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL div_lower_tick: got %b expected 1", tick_o[1]);
    end
    for (int i = 0; i < 6; i++) begin
      clk_edge();
      n_checks++;
      if (tick_o[1] !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL div_lower_period: got %b expected %b", tick_o[1], 1'(i % 2));
      end
    end
  endtask

  task automatic test_step();
    int t, db_rise, ce_edge, pulses;
    mode_i = M_STEP;
    step_btn_i = 1'b0;
    repeat (8) clk_edge();
    step_btn_i = 1'b1;
    t = ecnt + 1;
    db_rise = -1; ce_edge = -1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) step_btn_i = 1'b0;
      clk_edge();
      n_checks++;
      if (db_btn_o !== m_db || cpu_ce_o !== m_ce) begin
        n_fail++;
        $display("FAIL step_model: got db=%b ce=%b expected db=%b ce=%b", db_btn_o, cpu_ce_o, m_db, m_ce);
      end
      if (db_btn_o === 1'b1 && db_rise < 0) db_rise = ecnt;
      if (cpu_ce_o === 1'b1) begin
        pulses++;
        ce_edge = ecnt;
      end
    end
    n_checks++;
    if (db_rise - t != DB + 1) begin
      n_fail++;
      $display("FAIL step_db_latency: got %0d expected %0d", db_rise - t, DB + 1);
    end
    n_checks++;
    if (pulses != 1 || ce_edge - t != DB + 2) begin
      n_fail++;
      $display("FAIL step_pulse: got %0d pulses at +%0d expected 1 at +%0d", pulses, ce_edge - t, DB + 2);
    end
    // glitch shorter than the stability window
    pulses = 0;
    step_btn_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) step_btn_i = 1'b0;
      clk_edge();
      if (db_btn_o !== 1'b0 || cpu_ce_o !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL step_glitch: got %0d active cycles expected 0", pulses);
    end
  endtask

  task automatic test_run_halt();
    int n;
    mode_i = M_RUN;
    ch_en_i = 4'hF;
    set_div(0, 3);
    clk_edge();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      clk_edge();
      n_checks++;
      if (cpu_ce_o !== m_ce || tick_o[0] !== m_tick[0]) begin
        n_fail++;
        $display("FAIL run_ce: got ce=%b tick=%b expected ce=%b tick=%b", cpu_ce_o, tick_o[0], m_ce, m_tick[0]);
      end
      if (cpu_ce_o === 1'b1) n++;
    end
    n_checks++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL run_ce_count: got %0d expected 4", n);
    end
    mode_i = M_HALT;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      clk_edge();
      if (cpu_ce_o !== 1'b0) n++;
    end
    n_checks++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL halt_ce: got %0d pulses expected 0", n);
    end
  endtask

  task automatic test_halt_then_step();
    int n;
    logic seen_db;
    mode_i = M_HALT;
    step_btn_i = 1'b1;
    seen_db = 1'b0;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 8) step_btn_i = 1'b0;
      if (i == 12) mode_i = M_STEP;
      clk_edge();
      if (db_btn_o === 1'b1) seen_db = 1'b1;
      if (cpu_ce_o === 1'b1) n++;
    end
    n_checks++;
    if (seen_db !== 1'b1 || n != 0) begin
      n_fail++;
      $display("FAIL halt_press_discard: got db_seen=%b pulses=%0d expected 1 0", seen_db, n);
    end
    step_btn_i = 1'b1;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 8) step_btn_i = 1'b0;
      clk_edge();
      n_checks++;
      if (cpu_ce_o !== m_ce) begin
        n_fail++;
        $display("FAIL step_after_halt_model: got %b expected %b", cpu_ce_o, m_ce);
      end
      if (cpu_ce_o === 1'b1) n++;
    end
    n_checks++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL step_after_halt: got %0d pulses expected 1", n);
    end
  endtask

  task automatic test_wrap_and_reenable();
    logic [CW-1:0] prev;
    logic          wrapped;
    int            first;
    prev = clkdiv_o;
    wrapped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      n_checks++;
      if (clkdiv_o !== m_clkdiv) begin
        n_fail++;
        $display("FAIL clkdiv: got %0d expected %0d", clkdiv_o, m_clkdiv);
      end
      if (prev == 4'd15 && clkdiv_o == 4'd0) wrapped = 1'b1;
      prev = clkdiv_o;
    end
    n_checks++;
    if (wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL clkdiv_wrap: got %b expected 1", wrapped);
    end
    set_div(2, 4);
    ch_en_i = 4'hF;
    repeat (6) clk_edge();
    ch_en_i[2] = 1'b0;
    clk_edge();
    n_checks++;
    if (tick_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL ch2_disabled: got %b expected 0", tick_o[2]);
    end
    ch_en_i[2] = 1'b1;
    first = -1;
    for (int i = 1; i <= 10 && first < 0; i++) begin
      clk_edge();
      if (tick_o[2] === 1'b1) first = i;
    end
    n_checks++;
    if (first != 4) begin
      n_fail++;
      $display("FAIL ch2_reenable: got first tick at edge %0d expected 4", first);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        for (int k = 0; k < NCH; k++) set_div(k, $urandom_range(0, 6));
      end
      for (int k = 0; k < NCH; k++) ch_en_i[k] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) mode_i = 2'($urandom_range(0, 3));
      if (hold == 0) begin
        step_btn_i = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      clk_edge();
      n_checks++;
      if (tick_o !== m_tick || clkdiv_o !== m_clkdiv || cpu_ce_o !== m_ce || db_btn_o !== m_db) begin
        n_fail++;
        $display("FAIL random cycle %0d: got tick=%b cnt=%0d ce=%b db=%b expected tick=%b cnt=%0d ce=%b db=%b",
                 i, tick_o, clkdiv_o, cpu_ce_o, db_btn_o, m_tick, m_clkdiv, m_ce, m_db);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    ecnt       = 0;
    rst_n      = 1'b0;
    div_i      = '0;
    ch_en_i    = '0;
    mode_i     = M_HALT;
    step_btn_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_channels();
    test_step();
    test_run_halt();
    test_halt_then_step();
    test_wrap_and_reenable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Parametrised clock-enable generator; successor to the single-output clock divider. Runs one free-running cycle counter and NUM_CH independent programmable divide channels. Each channel emits single-cycle enable ticks, not derived clocks. Also provides a CPU clock-enable with run, debounced single-step and halt modes, so the CPU, display and peripheral logic all sit on the one board clock.

## Interface
Parameters:
- NUM_CH, 4, number of divide channels (≥1)
- DIV_W, 16, width of each channel divisor
- CNT_W, 32, width of the free-running counter
- DB_CYCLES, 20'd1_000_000, cycles of stable input required to accept a step-button change (≥1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- div_i  in  NUM_CH*DIV_W  channel k divisor at bits [k*DIV_W +: DIV_W]
- ch_en_i  in  NUM_CH  per-channel enable
- mode_i  in  2  CPU enable mode: 0 RUN, 1 STEP, 2 HALT, 3 treated as HALT
- step_btn_i  in  1  raw asynchronous push button, active-high
- clkdiv_o  out  CNT_W  free-running counter
- tick_o  out  NUM_CH  one-cycle enable pulse per channel
- cpu_ce_o  out  1  CPU clock enable
- db_btn_o  out  1  debounced button level

## Operation
- Reset values: clkdiv_o=0, tick_o=0, cpu_ce_o=0, db_btn_o=0, all channel counters=0, debounce counter=0, both sync flops=0.
- clkdiv_o increments by 1 each cycle and wraps from 2^CNT_W−1 to 0.
- Channel k, ch_en_i[k]=1, effective divisor D=max(div_i[k],1):
  - Counter c counts 0..D−1.
  - tick_o[k]=1 in the cycle after c==D−1 is registered; c then returns to 0.
  - Period is exactly D cycles; D=1 gives tick_o[k] high every cycle.
  - Terminal test is c ≥ D−1, so lowering div_i below the current count ticks on the next cycle and restarts.
- ch_en_i[k]=0: c forced to 0, tick_o[k]=0 from the next cycle. On re-enable, the first tick comes D cycles after the enable is sampled.
- Step path:
  - step_btn_i passes through 2-flop synchroniser s0→s1.
  - Debounce counter clears whenever s1==db_btn_o; it increments while they differ.
  - When the counter reaches DB_CYCLES−1 and they still differ, db_btn_o takes s1 and the counter clears.
- CPU enable:
  - RUN: cpu_ce_o = registered copy of channel 0 terminal condition, identical to tick_o[0].
  - STEP: cpu_ce_o=1 for exactly one cycle per 0→1 transition of db_btn_o; the rising edge is detected against a delayed copy.
  - HALT: cpu_ce_o=0.
  - Mode sampled every cycle. A rising edge of db_btn_o occurring while mode≠STEP is discarded, not queued. Debouncing continues in every mode.
- Simultaneous events: a step edge and a mode change in the same cycle use the new mode_i value.
- rst_n low at any time clears all state asynchronously. Operation restarts from reset values on the first rising edge after deassertion.

## Timing
- All outputs registered; no combinational input→output path.
- Channel: div_i/ch_en_i sampled at edge n affect tick_o from edge n+1.
- Button: step_btn_i held high, first sampled at edge t:
  - s1 high at t+1.
  - db_btn_o high at edge t+DB_CYCLES+1.
  - cpu_ce_o high for the single cycle after edge t+DB_CYCLES+2 (STEP mode).
- A glitch shorter than DB_CYCLES cycles produces no db_btn_o change.
- Release follows the same latency. The falling edge of db_btn_o never produces cpu_ce_o.

## Structure
- Package clk_en_pkg: mode encodings MODE_RUN/MODE_STEP/MODE_HALT, default DB_CYCLES, DIV_W.
- Sub-module btn_debounce: synchroniser, debounce counter, db level and rise-pulse outputs; parameter DB_CYCLES.
- Channels built with a generate loop in clk_en_gen.

## Test plan
- Reset mid-count with div_i[0]=5, deassert -> all outputs 0; first tick_o[0] on the 5th edge after release; period 5 thereafter.
- Channels 0–3 with div 1,2,3,0 -> ticks every 1,2,3,1 cycles. Change ch1 div 8→2 while c=6 -> tick next cycle, then period 2.
- DB_CYCLES=4, STEP, button high for 10 cycles -> db_btn_o rises at t+5, one cpu_ce_o pulse at t+6, none on release. 3-cycle glitch -> no pulse.
- RUN with div_i[0]=3 -> cpu_ce_o identical to tick_o[0]. Switch to HALT -> cpu_ce_o 0 next cycle.
- Button press debounced during HALT, then switch to STEP -> no cpu_ce_o pulse. Next press -> exactly one pulse.
- CNT_W=4 -> clkdiv_o wraps 15→0; ch_en_i[2] toggled off for one cycle -> counter cleared, next tick D cycles later.
